// File: rtl/mem_arb_pkg.sv
// Shared state encoding and owner/fetch constants for the unified memory-port arbiter.
// Round-robin arbitration is selected by defining MEM_ARB_RR_EN; fixed data priority otherwise.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_RESP = 2'd2
  } arb_state_e;

  localparam logic OWN_I = 1'b0;
  localparam logic OWN_D = 1'b1;

  // Fetch is always a full-word read: these bits are replicated to the port width.
  localparam logic FETCH_BE_BIT    = 1'b1;
  localparam logic FETCH_WDATA_BIT = 1'b0;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational owner picker for the memory-port arbiter.
// MEM_ARB_RR_EN defined: a tie goes to whoever did not own last; undefined: data wins ties.
module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic i_req,
  input  logic d_req,
  input  logic last_owner,
  output logic winner
);

  always_comb begin
    // With nothing pending the result is unused; holding last_owner keeps it stable.
    winner = last_owner;
    if (i_req && d_req) begin
`ifdef MEM_ARB_RR_EN
      winner = ~last_owner;
`else
      winner = OWN_D;
`endif
    end else if (d_req) begin
      winner = OWN_D;
    end else if (i_req) begin
      winner = OWN_I;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the single memory port between fetch and load/store, one transaction at a time.
// Define MEM_ARB_RR_EN for round-robin arbitration; the default build uses fixed data priority.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            i_req,
  input  logic [AW-1:0]   i_addr,
  output logic            i_gnt,
  output logic            i_rvalid,
  output logic [DW-1:0]   i_rdata,
  input  logic            d_req,
  input  logic [AW-1:0]   d_addr,
  input  logic            d_we,
  input  logic [DW/8-1:0] d_be,
  input  logic [DW-1:0]   d_wdata,
  output logic            d_gnt,
  output logic            d_rvalid,
  output logic [DW-1:0]   d_rdata,
  output logic            mem_req,
  output logic [AW-1:0]   mem_addr,
  output logic            mem_we,
  output logic [DW/8-1:0] mem_be,
  output logic [DW-1:0]   mem_wdata,
  input  logic            mem_gnt,
  input  logic            mem_rvalid,
  input  logic [DW-1:0]   mem_rdata,
  output logic            sel,
  output logic            busy
);

  arb_state_e state_q, state_d;
  logic       sel_q, sel_d;
  logic       busy_q, busy_d;
  logic       last_owner;
  logic       winner;
  logic       any_req;

`ifdef MEM_ARB_RR_EN
  logic last_q, last_d;
  assign last_owner = last_q;
`else
  assign last_owner = OWN_D;
`endif

  assign any_req = i_req || d_req;

  mem_arb_pick u_pick (
    .i_req      (i_req),
    .d_req      (d_req),
    .last_owner (last_owner),
    .winner     (winner)
  );

  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    mem_req  = 1'b0;
    i_gnt    = 1'b0;
    d_gnt    = 1'b0;
    i_rvalid = 1'b0;
    d_rvalid = 1'b0;
`ifdef MEM_ARB_RR_EN
    last_d   = last_q;
`endif
    case (state_q)
      IDLE: begin
        if (any_req) begin
          sel_d   = winner;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        mem_req = 1'b1;
        if (mem_gnt) begin
          i_gnt   = (sel_q == OWN_I);
          d_gnt   = (sel_q == OWN_D);
          state_d = WAIT_RESP;
`ifdef MEM_ARB_RR_EN
          last_d  = sel_q;
`endif
        end
      end
      WAIT_RESP: begin
        if (mem_rvalid) begin
          i_rvalid = (sel_q == OWN_I);
          d_rvalid = (sel_q == OWN_D);
          // Re-arbitrate in the response cycle so back-to-back requests skip IDLE.
          if (any_req) begin
            sel_d   = winner;
            state_d = ISSUE;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      sel_q   <= OWN_I;
      busy_q  <= 1'b0;
`ifdef MEM_ARB_RR_EN
      last_q  <= OWN_D;
`endif
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      busy_q  <= busy_d;
`ifdef MEM_ARB_RR_EN
      last_q  <= last_d;
`endif
    end
  end

  assign sel       = sel_q;
  assign busy      = busy_q;
  assign mem_addr  = sel_q ? d_addr  : i_addr;
  assign mem_we    = sel_q ? d_we    : 1'b0;
  assign mem_be    = sel_q ? d_be    : {(DW/8){FETCH_BE_BIT}};
  assign mem_wdata = sel_q ? d_wdata : {DW{FETCH_WDATA_BIT}};
  assign i_rdata   = mem_rdata;
  assign d_rdata   = mem_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: a transaction-level arbitration model predicts
// each grant; a negedge monitor pops and compares grants and responses.
`timescale 1ns/1ps
module tb_mem_port_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int BW = DW / 8;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          i_req = 1'b0;
  logic [AW-1:0] i_addr = '0;
  logic          i_gnt, i_rvalid;
  logic [DW-1:0] i_rdata;
  logic          d_req = 1'b0;
  logic [AW-1:0] d_addr = '0;
  logic          d_we = 1'b0;
  logic [BW-1:0] d_be = '0;
  logic [DW-1:0] d_wdata = '0;
  logic          d_gnt, d_rvalid;
  logic [DW-1:0] d_rdata;
  logic          mem_req;
  logic [AW-1:0] mem_addr;
  logic          mem_we;
  logic [BW-1:0] mem_be;
  logic [DW-1:0] mem_wdata;
  logic          mem_gnt = 1'b0;
  logic          mem_rvalid = 1'b0;
  logic [DW-1:0] mem_rdata = '0;
  logic          sel, busy;

  always #5 clk = ~clk;

  mem_port_arbiter #(.AW(AW), .DW(DW)) dut (
    .clk(clk), .reset_n(reset_n),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
    .d_req(d_req), .d_addr(d_addr), .d_we(d_we), .d_be(d_be), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_we(mem_we), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .sel(sel), .busy(busy)
  );

  typedef struct {
    logic          owner;
    logic [AW-1:0] addr;
    logic          we;
    logic [BW-1:0] be;
    logic [DW-1:0] wdata;
  } txn_t;

  txn_t exp_q[$];
  txn_t resp_q[$];
  logic gnt_log[$];

  int total = 0;
  int bad   = 0;

  logic model_busy = 1'b0;
  logic model_sel  = 1'b0;
  logic model_last = 1'b1;
  logic resp_real  = 1'b0;

  logic i_gnt_n = 1'b0, d_gnt_n = 1'b0, acc_n = 1'b0;
  int   cnt_ig = 0, cnt_dg = 0, cnt_ir = 0, cnt_dr = 0;
  logic [DW-1:0] last_i_rdata = '0;
  int   wd = 0;

  int   p_gnt = 50, p_stray = 0, p_ireq = 0, p_dreq = 0;
  int   min_dly = 0, max_dly = 2;
  logic use_fix = 1'b0;
  logic [DW-1:0] fix_val = '0;
  logic mem_out = 1'b0;
  int   mem_cnt = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic bit rnd(input int p);
    return $urandom_range(99, 0) < p;
  endfunction

  // Policy: a lone request wins; on a tie RR picks whoever did not own last, fixed picks data.
  function automatic logic pick(input logic ir, input logic dr, input logic last);
    if (ir && dr) begin
`ifdef MEM_ARB_RR_EN
      return !last;
`else
      return 1'b1;
`endif
    end
    return dr;
  endfunction

  // Transaction-level model: the port is either free or owned; it frees on a real response
  // and is claimed by the policy winner whenever it is free and someone is pending.
  always @(posedge clk) begin : model
    logic b, w;
    txn_t t;
    if (!reset_n) begin
      model_busy <= 1'b0;
      model_sel  <= 1'b0;
      model_last <= 1'b1;
      exp_q.delete();
    end else begin
      b = model_busy && !resp_real;
      if (!b && (i_req || d_req)) begin
        w = pick(i_req, d_req, model_last);
        t.owner = w;
        if (w) begin
          t.addr = d_addr; t.we = d_we; t.be = d_be; t.wdata = d_wdata;
        end else begin
          t.addr = i_addr; t.we = 1'b0; t.be = '1; t.wdata = '0;
        end
        exp_q.push_back(t);
        model_busy <= 1'b1;
        model_sel  <= w;
        model_last <= w;
      end else begin
        model_busy <= b;
      end
    end
  end

  always @(negedge clk) begin : monitor
    txn_t t;
    if (!reset_n) begin
      i_gnt_n = 1'b0; d_gnt_n = 1'b0; acc_n = 1'b0; wd = 0;
      resp_q.delete();
    end else begin
      i_gnt_n = i_gnt;
      d_gnt_n = d_gnt;
      acc_n   = mem_req && mem_gnt;
      chk("busy", 64'(busy), 64'(model_busy));
      chk("sel", 64'(sel), 64'(model_sel));
      if (!model_busy) chk("mem_req_idle", 64'(mem_req), 64'(0));
      if (i_gnt || d_gnt) begin
        chk("gnt_onehot", 64'(i_gnt && d_gnt), 64'(0));
        if (exp_q.size() == 0) begin
          chk("gnt_unexpected", 64'(exp_q.size()), 64'(1));
        end else begin
          t = exp_q.pop_front();
          chk("gnt_owner", 64'(d_gnt), 64'(t.owner));
          chk("gnt_mem_req", 64'(mem_req), 64'(1));
          chk("mem_addr", 64'(mem_addr), 64'(t.addr));
          chk("mem_we", 64'(mem_we), 64'(t.we));
          chk("mem_be", 64'(mem_be), 64'(t.be));
          chk("mem_wdata", 64'(mem_wdata), 64'(t.wdata));
          resp_q.push_back(t);
          gnt_log.push_back(t.owner);
        end
        if (i_gnt) cnt_ig++;
        if (d_gnt) cnt_dg++;
      end
      chk("rvalid_fwd", 64'(i_rvalid || d_rvalid), 64'(resp_real));
      if (i_rvalid || d_rvalid) begin
        chk("rvalid_onehot", 64'(i_rvalid && d_rvalid), 64'(0));
        if (resp_q.size() == 0) begin
          chk("rvalid_unexpected", 64'(resp_q.size()), 64'(1));
        end else begin
          t = resp_q.pop_front();
          chk("rvalid_owner", 64'(d_rvalid), 64'(t.owner));
          chk("rdata", 64'(t.owner ? d_rdata : i_rdata), 64'(mem_rdata));
          $display("txn owner=%s we=%0d addr=%h rdata=%h", t.owner ? "D" : "I", t.we, t.addr, mem_rdata);
        end
        if (i_rvalid) begin cnt_ir++; last_i_rdata = i_rdata; end
        if (d_rvalid) cnt_dr++;
      end
      wd = (exp_q.size() > 0) ? wd + 1 : 0;
      if (wd == 200) chk("gnt_watchdog", 64'(wd), 64'(0));
    end
  end

  // One clock of requester and memory behaviour, driven just after the rising edge.
  task automatic env_cycle();
    @(posedge clk); #1;
    if (i_gnt_n) i_req = 1'b0;
    if (d_gnt_n) d_req = 1'b0;
    if (!i_req && rnd(p_ireq)) begin
      i_req = 1'b1; i_addr = AW'($urandom);
    end
    if (!d_req && rnd(p_dreq)) begin
      d_req = 1'b1; d_addr = AW'($urandom); d_we = 1'($urandom);
      d_be = BW'($urandom); d_wdata = DW'($urandom);
    end
    mem_rvalid = 1'b0;
    resp_real  = 1'b0;
    if (acc_n) begin
      mem_out = 1'b1;
      mem_cnt = int'($urandom_range(max_dly, min_dly));
    end
    if (mem_out) begin
      if (mem_cnt == 0) begin
        mem_rvalid = 1'b1; resp_real = 1'b1; mem_out = 1'b0;
        mem_rdata = use_fix ? fix_val : DW'($urandom);
      end else begin
        mem_cnt--;
      end
    end else if (rnd(p_stray)) begin
      mem_rvalid = 1'b1; mem_rdata = DW'($urandom);
    end
    mem_gnt = rnd(p_gnt);
  endtask

  task automatic apply_reset();
    reset_n = 1'b0; i_req = 1'b0; d_req = 1'b0; mem_gnt = 1'b0;
    mem_rvalid = 1'b0; resp_real = 1'b0; mem_out = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
  endtask

  initial begin : stim
    int c0, c1, c2, c3;
    logic exp_o;

    // Reset state and fetch-only transaction.
    apply_reset();
    @(negedge clk);
    chk("rst_mem_req", 64'(mem_req), 64'(0));
    chk("rst_i_gnt", 64'(i_gnt), 64'(0));
    chk("rst_d_gnt", 64'(d_gnt), 64'(0));
    chk("rst_i_rvalid", 64'(i_rvalid), 64'(0));
    chk("rst_d_rvalid", 64'(d_rvalid), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_sel", 64'(sel), 64'(0));
    c0 = cnt_ig; c1 = cnt_ir; c2 = cnt_dg; c3 = cnt_dr;
    i_req = 1'b1; i_addr = 32'h100; p_gnt = 100; min_dly = 0; max_dly = 0;
    use_fix = 1'b1; fix_val = 32'hDEADBEEF;
    repeat (6) env_cycle();
    chk("fetch_i_gnt_cnt", 64'(cnt_ig - c0), 64'(1));
    chk("fetch_i_rvalid_cnt", 64'(cnt_ir - c1), 64'(1));
    chk("fetch_d_gnt_cnt", 64'(cnt_dg - c2), 64'(0));
    chk("fetch_d_rvalid_cnt", 64'(cnt_dr - c3), 64'(0));
    chk("fetch_rdata", 64'(last_i_rdata), 64'(32'hDEADBEEF));
    use_fix = 1'b0;

    // Tie after reset with both requests held continuously.
    apply_reset();
    gnt_log.delete();
    c0 = cnt_ig;
    i_req = 1'b1; i_addr = AW'($urandom);
    d_req = 1'b1; d_addr = AW'($urandom); d_we = 1'b0; d_be = '1; d_wdata = '0;
    p_ireq = 100; p_dreq = 100; p_gnt = 100; max_dly = 1;
    for (int k = 0; k < 200 && gnt_log.size() < 4; k++) env_cycle();
    chk("tie_grants_seen", 64'(gnt_log.size() >= 4), 64'(1));
    for (int k = 0; k < 4 && k < gnt_log.size(); k++) begin
`ifdef MEM_ARB_RR_EN
      exp_o = (k % 2 == 1);
`else
      exp_o = 1'b1;
`endif
      chk("tie_order", 64'(gnt_log[k]), 64'(exp_o));
    end
`ifdef MEM_ARB_RR_EN
    chk("tie_i_gnt_cnt", 64'(cnt_ig - c0), 64'(2));
`else
    chk("tie_i_gnt_cnt", 64'(cnt_ig - c0), 64'(0));
`endif
    p_ireq = 0; p_dreq = 0;
    repeat (40) env_cycle();

    // Store stalled by memory for three ISSUE cycles.
    c2 = cnt_dg;
    p_gnt = 0;
    d_req = 1'b1; d_we = 1'b1; d_be = 4'h3; d_wdata = 32'h1234; d_addr = 32'h200;
    env_cycle();
    repeat (3) begin
      @(negedge clk);
      chk("store_mem_req", 64'(mem_req), 64'(1));
      chk("store_mem_we", 64'(mem_we), 64'(1));
      chk("store_mem_be", 64'(mem_be), 64'(4'h3));
      chk("store_mem_wdata", 64'(mem_wdata), 64'(32'h1234));
      chk("store_d_gnt_stall", 64'(d_gnt), 64'(0));
      env_cycle();
    end
    mem_gnt = 1'b1;
    @(negedge clk);
    chk("store_mem_req_last", 64'(mem_req), 64'(1));
    chk("store_mem_we_last", 64'(mem_we), 64'(1));
    chk("store_d_gnt", 64'(d_gnt), 64'(1));
    p_gnt = 100;
    repeat (10) env_cycle();
    chk("store_d_gnt_cnt", 64'(cnt_dg - c2), 64'(1));

    // Back-to-back: data request pending when the fetch response arrives.
    i_req = 1'b1; i_addr = AW'($urandom); min_dly = 0; max_dly = 0;
    env_cycle();
    env_cycle();
    d_req = 1'b1; d_addr = AW'($urandom); d_we = 1'b0; d_be = '1; d_wdata = '0;
    env_cycle();
    @(negedge clk);
    chk("b2b_sel", 64'(sel), 64'(1));
    chk("b2b_mem_req", 64'(mem_req), 64'(1));
    chk("b2b_mem_addr", 64'(mem_addr), 64'(d_addr));
    chk("b2b_busy", 64'(busy), 64'(1));
    repeat (10) env_cycle();

    // Reset while waiting for a response, then a late mem_rvalid.
    i_req = 1'b1; i_addr = AW'($urandom); min_dly = 3; max_dly = 3;
    env_cycle();
    env_cycle();
    reset_n = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1; mem_out = 1'b0; i_req = 1'b0; d_req = 1'b0; mem_gnt = 1'b0;
    mem_rvalid = 1'b1; resp_real = 1'b0;
    @(negedge clk);
    chk("rst_wait_i_rvalid", 64'(i_rvalid), 64'(0));
    chk("rst_wait_d_rvalid", 64'(d_rvalid), 64'(0));
    chk("rst_wait_busy", 64'(busy), 64'(0));
    chk("rst_wait_sel", 64'(sel), 64'(0));
    // Stray response while idle.
    @(posedge clk); #1;
    @(negedge clk);
    chk("stray_i_rvalid", 64'(i_rvalid), 64'(0));
    chk("stray_d_rvalid", 64'(d_rvalid), 64'(0));
    chk("stray_busy", 64'(busy), 64'(0));

    // Randomised traffic with stray responses and variable memory latency.
    p_ireq = 30; p_dreq = 30; p_gnt = 60; p_stray = 15; min_dly = 0; max_dly = 3;
    c0 = cnt_ig + cnt_dg;
    repeat (3000) env_cycle();
    p_ireq = 0; p_dreq = 0; p_stray = 0; p_gnt = 100;
    repeat (60) env_cycle();
    chk("random_activity", 64'((cnt_ig + cnt_dg - c0) > 50), 64'(1));
    chk("exp_q_drained", 64'(exp_q.size()), 64'(0));
    chk("resp_q_drained", 64'(resp_q.size()), 64'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Two-requester arbiter sharing the single unified memory port between instruction fetch and load/store in the RV32I core. It chooses an owner, drives the owner select to the address/write-data steering, and holds ownership through one request/response transaction. It returns each response only to the requester that issued it. It sits between the fetch and LSU front-ends and the memory interface.

## Interface
- AW, 32, address width
- DW, 32, data width (byte enables are DW/8 bits)

- clk  in  1  clock; all state changes on the rising edge
- reset_n  in  1  synchronous, active-low reset
- i_req  in  1  fetch request; held with i_addr until i_gnt
- i_addr  in  AW  fetch address
- i_gnt  out  1  one-cycle pulse when the fetch request is accepted by memory
- i_rvalid  out  1  one-cycle pulse when fetch read data is valid
- i_rdata  out  DW  fetch read data (mem_rdata passthrough)
- d_req  in  1  data request; held with all d_* fields until d_gnt
- d_addr  in  AW  data address
- d_we  in  1  1 = store, 0 = load
- d_be  in  DW/8  store byte enables
- d_wdata  in  DW  store data
- d_gnt  out  1  one-cycle pulse when the data request is accepted
- d_rvalid  out  1  one-cycle pulse when load data is valid or a store is acknowledged
- d_rdata  out  DW  load data (mem_rdata passthrough)
- mem_req  out  1  request to memory
- mem_addr  out  AW  owner's address
- mem_we  out  1  owner's write enable (0 for fetch)
- mem_be  out  DW/8  owner's byte enables (all ones for fetch)
- mem_wdata  out  DW  owner's write data (0 for fetch)
- mem_gnt  in  1  memory accepts the request this cycle
- mem_rvalid  in  1  memory response this cycle (reads and writes both respond)
- mem_rdata  in  DW  memory read data
- sel  out  1  registered owner; 0 = fetch, 1 = data
- busy  out  1  high whenever the state is not IDLE

## Operation
- FSM states: IDLE, ISSUE, WAIT_RESP.
- IDLE: if any request is pending, pick an owner, register it into sel, and go to ISSUE. Otherwise stay in IDLE.
- ISSUE: mem_req=1 and mem_* are steered by sel. When mem_gnt=1, pulse x_gnt for the owner and go to WAIT_RESP.
- WAIT_RESP: mem_req=0. When mem_rvalid=1, pulse x_rvalid for the owner. In the same cycle, re-arbitrate: if any request is pending, load the new owner and go to ISSUE; otherwise go to IDLE.
- Exactly one outstanding transaction at a time. Ownership never changes in ISSUE or WAIT_RESP.
- mem_rvalid in IDLE or ISSUE is ignored: no rvalid is forwarded and the state does not change.
- x_gnt and x_rvalid are never asserted for the non-owner.
- The non-owner's request is ignored until re-arbitration. It must remain held by its requester.
- Arbitration policy is described under Configuration.

## Timing
- Reset (reset_n=0 at an edge):
  - state=IDLE, sel=0, busy=0.
  - mem_req, i_gnt, d_gnt, i_rvalid, d_rvalid are all 0.
  - Round-robin last-owner register = 1 (data), so fetch wins the first tie.
- Reset mid-transaction abandons the transaction. No gnt or rvalid is issued for it.
- Minimum latency, request to mem_req: 1 cycle (IDLE→ISSUE).
- Minimum latency, request to rvalid: 3 cycles with mem_gnt in the first ISSUE cycle and mem_rvalid one cycle later.
- Back-to-back transactions: ISSUE directly follows the WAIT_RESP cycle that received mem_rvalid. There is no IDLE bubble.
- mem_gnt and mem_rvalid are both combinational inputs to the next-state logic.
- x_gnt and x_rvalid are combinational: x_gnt = (state==ISSUE)&&mem_gnt&&owner; x_rvalid is the analogous term for WAIT_RESP and mem_rvalid.
- sel and busy are registered.

## Configuration
- MEM_ARB_RR_EN defined: round-robin. A last-owner register updates on each gnt. When both requesters are pending, the one that is not the last owner wins.
- MEM_ARB_RR_EN undefined: fixed priority. Data always wins a tie. The last-owner register is not built.
- A single request is always granted in both modes.

## Structure
- Shared package mem_arb_pkg contains:
  - the state enum: IDLE=2'd0, ISSUE=2'd1, WAIT_RESP=2'd2;
  - owner constants OWN_I=1'b0, OWN_D=1'b1;
  - the fetch constants for mem_be (all ones) and mem_wdata (zero).
- One sub-module, mem_arb_pick: a combinational picker. Inputs are i_req, d_req, last_owner; output is the winner. The MEM_ARB_RR_EN policy lives there.
- The FSM, owner register and output steering stay in the top module.

## Test plan
- Fetch only: i_addr=0x100, mem_gnt on the first ISSUE cycle, mem_rvalid next cycle with rdata=0xDEADBEEF → i_gnt once, i_rvalid once with i_rdata=0xDEADBEEF, d_gnt and d_rvalid stay 0, sel=0 throughout.
- Tie after reset: both requests held continuously.
  - RR build: grant order I, D, I, D.
  - Fixed build: D, D, D, with i_gnt never asserted while d_req is held.
- Store: d_we=1, d_be=0x3, d_wdata=0x1234, mem_gnt held low for 3 cycles → mem_req held high with mem_we=1, mem_be=0x3 for all 4 ISSUE cycles; d_gnt pulses only on the mem_gnt cycle.
- Back-to-back: d_req pending when fetch's mem_rvalid arrives → ISSUE in the next cycle with sel=1 and mem_addr=d_addr; no IDLE cycle.
- Reset in WAIT_RESP: then mem_rvalid=1 the cycle after reset → no rvalid to either requester; state IDLE, busy=0, sel=0.
- Stray mem_rvalid in IDLE → ignored; no x_rvalid, state stays IDLE.
